ex_mem_pipe: RTL

- Parametrised EX/MEM pipeline register for the pipelined core, sitting between the EXE stage and the MEM stage.
- Registers the EXE control bits (write_reg, mem_to_reg, write_mem), alu_result, write_mem_val and the destination register.
- Adds a valid/ready handshake with a two-entry skid buffer, so a stalling MEM stage does not create a combinational ready path back to EXE.
- Also provides a synchronous flush, optional suppression of writes to register 0, and forwarding/load-use outputs for the hazard unit.

---
 rtl/ex_mem_pipe.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with a two-entry skid buffer (head + skid), synchronous flush,
// optional r0 write suppression and forwarding / load-use outputs for the hazard unit.
module ex_mem_pipe #(
  parameter int DATA_W            = 32,
  parameter int REG_ADDR_W        = 5,
  parameter int ZERO_REG_SUPPRESS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  exe_write_reg,
  input  logic                  exe_mem_to_reg,
  input  logic                  exe_write_mem,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     write_mem_val,
  input  logic [REG_ADDR_W-1:0] e_des_r,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  mem_write_reg,
  output logic                  mem_mem_to_reg,
  output logic                  mem_write_mem,
  output logic [DATA_W-1:0]     alu_result_o,
  output logic [DATA_W-1:0]     write_mem_val_o,
  output logic [REG_ADDR_W-1:0] e_des_r_o,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_reg,
  output logic [DATA_W-1:0]     fwd_data,
  output logic                  load_pending
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic                  write_reg;
    logic                  mem_to_reg;
    logic                  write_mem;
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     wmv;
    logic [REG_ADDR_W-1:0] des;
  } entry_t;

  state_t state_reg;
  entry_t head_reg;
  entry_t skid_reg;
  entry_t in_entry;
  entry_t fwd_src;
  logic   head_valid;
  logic   skid_valid;
  logic   accept;
  logic   pop;

  assign head_valid = (state_reg != EMPTY);
  assign skid_valid = (state_reg == FULL);
  assign in_ready   = !skid_valid;
  assign out_valid  = head_valid;
  assign accept     = in_valid && in_ready;
  assign pop        = head_valid && out_ready;

  always_comb begin
    in_entry            = '0;
    in_entry.write_reg  = exe_write_reg &&
                          !((ZERO_REG_SUPPRESS != 0) && (e_des_r == '0));
    in_entry.mem_to_reg = exe_mem_to_reg;
    in_entry.write_mem  = exe_write_mem;
    in_entry.alu        = alu_result;
    in_entry.wmv        = write_mem_val;
    in_entry.des        = e_des_r;
  end

  // Flush only clears valids; a concurrent pop needs no action since head data is simply left behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
      head_reg  <= '0;
      skid_reg  <= '0;
    end else if (flush) begin
      state_reg <= EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            head_reg  <= in_entry;
            state_reg <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_reg <= in_entry;
          end else if (accept) begin
            skid_reg  <= in_entry;
            state_reg <= FULL;
          end else if (pop) begin
            state_reg <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_reg  <= skid_reg;
            state_reg <= ONE;
          end
        end
        default: state_reg <= EMPTY;
      endcase
    end
  end

  assign mem_write_reg   = head_valid && head_reg.write_reg;
  assign mem_mem_to_reg  = head_valid && head_reg.mem_to_reg;
  assign mem_write_mem   = head_valid && head_reg.write_mem;
  assign alu_result_o    = head_reg.alu;
  assign write_mem_val_o = head_reg.wmv;
  assign e_des_r_o       = head_reg.des;

  // The youngest held entry is the one the hazard unit must see first.
  assign fwd_src      = skid_valid ? skid_reg : head_reg;
  assign fwd_valid    = head_valid && fwd_src.write_reg && !fwd_src.mem_to_reg;
  assign load_pending = head_valid && fwd_src.write_reg && fwd_src.mem_to_reg;
  assign fwd_reg      = head_valid ? fwd_src.des : '0;
  assign fwd_data     = head_valid ? fwd_src.alu : '0;

endmodule
